// File: rtl/reg_file_sb_if.sv
// Bus interface for reg_file_sb: the write, reservation and dual read ports.
// The master (issue/writeback logic) drives requests; the slave (register file) answers.
interface reg_file_sb_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 5
);
    logic              CLR;
    logic              WE;
    logic [ADDR_W-1:0] DEST_ADDRESS;
    logic [WIDTH-1:0]  IN;
    logic              RES_REQ;
    logic [ADDR_W-1:0] RES_ADDRESS;
    logic              RES_ACK;
    logic [ADDR_W-1:0] SOURCE_ADDRESS_1;
    logic [ADDR_W-1:0] SOURCE_ADDRESS_2;
    logic [WIDTH-1:0]  RD1;
    logic [WIDTH-1:0]  RD2;
    logic              RD1_VALID;
    logic              RD2_VALID;
    logic [CNT_W-1:0]  BUSY_COUNT;

    modport master (
        output CLR, WE, DEST_ADDRESS, IN, RES_REQ, RES_ADDRESS,
               SOURCE_ADDRESS_1, SOURCE_ADDRESS_2,
        input  RES_ACK, RD1, RD2, RD1_VALID, RD2_VALID, BUSY_COUNT
    );

    modport slave (
        input  CLR, WE, DEST_ADDRESS, IN, RES_REQ, RES_ADDRESS,
               SOURCE_ADDRESS_1, SOURCE_ADDRESS_2,
        output RES_ACK, RD1, RD2, RD1_VALID, RD2_VALID, BUSY_COUNT
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with 2 combinational read ports, 1 write port and per-entry busy scoreboard.
// Optional macro REG_FILE_SB_BYPASS_EN forwards the write data to matching read ports.
module reg_file_sb #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 5
) (
    input logic         CLK,
    input logic         RESET,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [CNT_W-1:0] busy_count;

    logic             res_ack;
    logic             release_busy;
    logic             same_addr;
    logic [CNT_W-1:0] count_next;

    // Reservation is refused on a busy entry even if this edge's write frees it.
    assign res_ack      = bus.RES_REQ & ~busy[bus.RES_ADDRESS] & ~bus.CLR;
    assign same_addr    = res_ack & bus.WE & (bus.RES_ADDRESS == bus.DEST_ADDRESS);
    assign release_busy = bus.WE & busy[bus.DEST_ADDRESS] & ~same_addr;

    always_comb begin
        count_next = busy_count;
        if (res_ack)
            count_next = count_next + CNT_W'(1);
        if (release_busy)
            count_next = count_next - CNT_W'(1);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else if (bus.CLR) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (bus.WE) begin
                regs[bus.DEST_ADDRESS] <= bus.IN;
                busy[bus.DEST_ADDRESS] <= 1'b0;
            end
            // Placed after the write so a same-address reservation leaves the entry busy.
            if (res_ack)
                busy[bus.RES_ADDRESS] <= 1'b1;
            busy_count <= count_next;
        end
    end

    assign bus.RES_ACK    = res_ack;
    assign bus.BUSY_COUNT = busy_count;

`ifdef REG_FILE_SB_BYPASS_EN
    logic fwd1;
    logic fwd2;

    assign fwd1          = bus.WE & (bus.SOURCE_ADDRESS_1 == bus.DEST_ADDRESS);
    assign fwd2          = bus.WE & (bus.SOURCE_ADDRESS_2 == bus.DEST_ADDRESS);
    assign bus.RD1       = fwd1 ? bus.IN : regs[bus.SOURCE_ADDRESS_1];
    assign bus.RD2       = fwd2 ? bus.IN : regs[bus.SOURCE_ADDRESS_2];
    assign bus.RD1_VALID = fwd1 | ~busy[bus.SOURCE_ADDRESS_1];
    assign bus.RD2_VALID = fwd2 | ~busy[bus.SOURCE_ADDRESS_2];
`else
    assign bus.RD1       = regs[bus.SOURCE_ADDRESS_1];
    assign bus.RD2       = regs[bus.SOURCE_ADDRESS_2];
    assign bus.RD1_VALID = ~busy[bus.SOURCE_ADDRESS_1];
    assign bus.RD2_VALID = ~busy[bus.SOURCE_ADDRESS_2];
`endif

    // The counter must always mirror the number of set busy bits.
    a_count_matches: assert property (@(posedge CLK) disable iff (RESET)
        busy_count == CNT_W'($countones(busy)));

    a_no_ack_on_clr: assert property (@(posedge CLK) disable iff (RESET)
        bus.CLR |-> !res_ack);
endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised and directed bench for reg_file_sb against an array/popcount reference model.
module tb_reg_file_sb;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    logic CLK = 1'b0;
    logic RESET;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [WIDTH-1:0] m_reg [DEPTH];
    bit               m_busy [DEPTH];

    always #5 CLK = ~CLK;

    reg_file_sb_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    reg_file_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++)
            c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        bus.CLR = 0; bus.WE = 0; bus.DEST_ADDRESS = '0; bus.IN = '0;
        bus.RES_REQ = 0; bus.RES_ADDRESS = '0;
        bus.SOURCE_ADDRESS_1 = '0; bus.SOURCE_ADDRESS_2 = '0;
    endtask

    // Called just after a falling edge with inputs applied; checks, clocks, updates model.
    task automatic step();
        logic [WIDTH-1:0] e1, e2;
        logic v1, v2, ack;
        #1;
        e1 = m_reg[bus.SOURCE_ADDRESS_1];
        e2 = m_reg[bus.SOURCE_ADDRESS_2];
        v1 = !m_busy[bus.SOURCE_ADDRESS_1];
        v2 = !m_busy[bus.SOURCE_ADDRESS_2];
`ifdef REG_FILE_SB_BYPASS_EN
        if (bus.WE && bus.SOURCE_ADDRESS_1 == bus.DEST_ADDRESS) begin e1 = bus.IN; v1 = 1; end
        if (bus.WE && bus.SOURCE_ADDRESS_2 == bus.DEST_ADDRESS) begin e2 = bus.IN; v2 = 1; end
`endif
        ack = bus.RES_REQ && !m_busy[bus.RES_ADDRESS] && !bus.CLR;
        check("rd1", bus.RD1, e1);
        check("rd2", bus.RD2, e2);
        check("rd1_valid", bus.RD1_VALID, v1);
        check("rd2_valid", bus.RD2_VALID, v2);
        check("res_ack", bus.RES_ACK, ack);
        check("busy_count", bus.BUSY_COUNT, m_count());
        @(posedge CLK);
        if (bus.CLR) begin
            m_clear();
        end else begin
            if (bus.WE) begin
                m_reg[bus.DEST_ADDRESS]  = bus.IN;
                m_busy[bus.DEST_ADDRESS] = 1'b0;
            end
            if (ack)
                m_busy[bus.RES_ADDRESS] = 1'b1;
        end
        @(negedge CLK);
    endtask

    initial begin
        idle();
        m_clear();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("reset_count", bus.BUSY_COUNT, 0);
        check("reset_rd1_valid", bus.RD1_VALID, 1);
        check("reset_rd1", bus.RD1, 0);

        // Build reg[3]=DEADBEEF with busy[3]=1, then reset asynchronously mid-cycle.
        idle(); bus.WE = 1; bus.DEST_ADDRESS = 3; bus.IN = 32'hDEADBEEF; step();
        idle(); bus.RES_REQ = 1; bus.RES_ADDRESS = 3; bus.SOURCE_ADDRESS_1 = 3; step();
        idle(); bus.SOURCE_ADDRESS_1 = 3; step();
        #2 RESET = 1'b1;
        #1;
        check("async_rst_rd1", bus.RD1, 0);
        check("async_rst_rd1_valid", bus.RD1_VALID, 1);
        check("async_rst_count", bus.BUSY_COUNT, 0);
        m_clear();
        @(negedge CLK);
        RESET = 1'b0;

        // Reserve 5, retry refused, then write releases it.
        idle(); bus.RES_REQ = 1; bus.RES_ADDRESS = 5; bus.SOURCE_ADDRESS_2 = 5; step();
        idle(); bus.RES_REQ = 1; bus.RES_ADDRESS = 5; bus.SOURCE_ADDRESS_2 = 5;
        #1;
        check("res5_retry_ack", bus.RES_ACK, 0);
        check("res5_valid", bus.RD2_VALID, 0);
        check("res5_count", bus.BUSY_COUNT, 1);
        #0 step();
        idle(); bus.WE = 1; bus.DEST_ADDRESS = 5; bus.IN = 32'h12345678; bus.SOURCE_ADDRESS_2 = 5;
`ifdef REG_FILE_SB_BYPASS_EN
        #1;
        check("bypass_rd2", bus.RD2, 32'h12345678);
        check("bypass_rd2_valid", bus.RD2_VALID, 1);
`endif
        step();
        idle(); bus.SOURCE_ADDRESS_2 = 5;
        #1;
        check("wr5_rd2", bus.RD2, 32'h12345678);
        check("wr5_valid", bus.RD2_VALID, 1);
        check("wr5_count", bus.BUSY_COUNT, 0);
        step();

        // Busy 7: write and reserve on the same edge.
        idle(); bus.RES_REQ = 1; bus.RES_ADDRESS = 7; step();
        idle(); bus.WE = 1; bus.DEST_ADDRESS = 7; bus.IN = 32'hA5A5A5A5;
        bus.RES_REQ = 1; bus.RES_ADDRESS = 7; step();
        idle(); bus.SOURCE_ADDRESS_1 = 7;
        #1;
        check("same7_rd1", bus.RD1, 32'hA5A5A5A5);
        check("same7_valid", bus.RD1_VALID, 1);
        check("same7_count", bus.BUSY_COUNT, 0);
        step();

        // Idle 9: write and reserve on the same edge leaves it busy.
        idle(); bus.WE = 1; bus.DEST_ADDRESS = 9; bus.IN = 32'h1;
        bus.RES_REQ = 1; bus.RES_ADDRESS = 9; step();
        idle(); bus.SOURCE_ADDRESS_1 = 9;
        #1;
        check("same9_rd1", bus.RD1, 32'h1);
        check("same9_valid", bus.RD1_VALID, 0);
        check("same9_count", bus.BUSY_COUNT, 1);
        step();

        // Fill the scoreboard, confirm refusals, then CLR beats a concurrent write.
        idle(); bus.CLR = 1; step();
        for (int a = 0; a < DEPTH; a++) begin
            idle(); bus.RES_REQ = 1; bus.RES_ADDRESS = ADDR_W'(a); step();
        end
        idle();
        #1;
        check("full_count", bus.BUSY_COUNT, DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            idle(); bus.RES_REQ = 1; bus.RES_ADDRESS = ADDR_W'(a); step();
        end
        idle(); bus.CLR = 1; bus.WE = 1; bus.DEST_ADDRESS = 2; bus.IN = 32'hFFFF0000;
        bus.RES_REQ = 1; bus.RES_ADDRESS = 4; step();
        for (int a = 0; a < DEPTH; a++) begin
            idle(); bus.SOURCE_ADDRESS_1 = ADDR_W'(a); bus.SOURCE_ADDRESS_2 = ADDR_W'(DEPTH - 1 - a);
            step();
        end

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            bus.CLR              = ($urandom_range(0, 49) == 0);
            bus.WE               = ($urandom_range(0, 2) == 0);
            bus.DEST_ADDRESS     = ADDR_W'($urandom);
            bus.IN               = $urandom;
            bus.RES_REQ          = ($urandom_range(0, 1) == 0);
            bus.RES_ADDRESS      = ADDR_W'($urandom);
            bus.SOURCE_ADDRESS_1 = ($urandom_range(0, 3) == 0) ? bus.DEST_ADDRESS : ADDR_W'($urandom);
            bus.SOURCE_ADDRESS_2 = ($urandom_range(0, 3) == 0) ? bus.RES_ADDRESS : ADDR_W'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file with two combinational read ports, one synchronous write port and a per-register scoreboard (busy bits).
- Serves the multicycle and pipelined datapaths. Issue logic reserves a destination register; writeback releases it. Read ports report operand validity, so the controller can stall.
- Generalises the fixed 16-entry file to 2**ADDR_W entries. Adds a synchronous clear, reservation handshake and busy-count tracking.

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers.
- CNT_W, 5, width of BUSY_COUNT; must satisfy 2**CNT_W > DEPTH.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- CLR  input  1  synchronous clear of all registers and busy bits.
- WE  input  1  write enable.
- DEST_ADDRESS  input  ADDR_W  write address.
- IN  input  WIDTH  write data.
- RES_REQ  input  1  reservation request.
- RES_ADDRESS  input  ADDR_W  register to reserve.
- RES_ACK  output  1  reservation accepted this cycle (combinational).
- SOURCE_ADDRESS_1  input  ADDR_W  read port 1 address.
- SOURCE_ADDRESS_2  input  ADDR_W  read port 2 address.
- RD1  output  WIDTH  read data, port 1.
- RD2  output  WIDTH  read data, port 2.
- RD1_VALID  output  1  register at SOURCE_ADDRESS_1 not busy.
- RD2_VALID  output  1  register at SOURCE_ADDRESS_2 not busy.
- BUSY_COUNT  output  CNT_W  number of busy registers (registered).

Behaviour:
- Reset (RESET=1, asynchronous, takes effect immediately regardless of CLK):
  - all registers = 0, all busy bits = 0, BUSY_COUNT = 0.
  - Resulting outputs: RD1 = RD2 = 0, RD1_VALID = RD2_VALID = 1.
- RESET mid-operation discards all pending reservations. Writes in the same cycle are lost.
- CLR=1 at a clock edge does the same as reset, synchronously, and has priority over WE and RES_REQ.
- RES_ACK is low while CLR=1.
- Reads:
  - RDn = reg[SOURCE_ADDRESS_n], combinational, zero latency.
  - RDn_VALID = ~busy[SOURCE_ADDRESS_n].
- Write: on the rising edge with WE=1, reg[DEST_ADDRESS] <= IN and busy[DEST_ADDRESS] <= 0.
  - Writing a non-busy register is legal: data updates, busy stays 0.
- Reservation handshake:
  - RES_ACK = RES_REQ & ~busy[RES_ADDRESS] & ~CLR.
  - On an edge with RES_ACK=1, busy[RES_ADDRESS] <= 1.
  - Request to an already-busy register: RES_ACK=0, no state change. The requester must hold RES_REQ and retry.
  - Exception: the same cycle's write releases that address. RES_ACK is still 0 that cycle (no lookahead); the request succeeds the next cycle.
- Simultaneous WE and accepted reservation to the same address:
  - data is written;
  - busy ends at 1 (reservation wins, new producer pending).
- Simultaneous to different addresses: both take effect independently.
- BUSY_COUNT: next value = current + (reservation accepted) − (WE to a busy address), excluding the same-address case above, where the count is unchanged.
  - Never wraps. The DEPTH bound follows from the busy bits, and CNT_W guarantees no overflow.
- All DEPTH registers are general-purpose; no hardwired entries.

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If WE=1 and SOURCE_ADDRESS_n == DEST_ADDRESS, then RDn = IN combinationally.
  - RDn_VALID = 1 in that cycle even if the register is busy.
- Undefined: reads return stored contents only, and RDn_VALID follows the busy bit. The written value appears on the cycle after the edge.

Test Plan:
- Assert RESET asynchronously mid-cycle with reg[3]=0xDEADBEEF and busy[3]=1 -> RD1 (addr 3) = 0 immediately; RD1_VALID=1; BUSY_COUNT=0.
- RES_REQ addr 5 -> RES_ACK=1. Next cycle: RD2_VALID(addr 5)=0, BUSY_COUNT=1. Second RES_REQ addr 5 -> RES_ACK=0, BUSY_COUNT stays 1.
- WE addr 5, IN=0x12345678 -> next cycle RD2=0x12345678, RD2_VALID=1, BUSY_COUNT=0. With BYPASS_EN: RD2=0x12345678 and RD2_VALID=1 in the write cycle itself.
- Same edge: WE addr 7 (busy) with IN=0xA5A5A5A5, plus RES_REQ addr 7 -> RES_ACK=0; reg[7]=0xA5A5A5A5; busy[7]=0; BUSY_COUNT decrements by 1.
- reg[9] idle; same edge: WE addr 9 with IN=0x1, plus RES_REQ addr 9 -> RES_ACK=1; reg[9]=0x1; busy[9]=1; BUSY_COUNT +1.
- Reserve all 16 registers (ADDR_W=4) -> BUSY_COUNT=16, all RES_REQ refused. Then CLR=1 with WE=1 -> all registers 0, BUSY_COUNT=0, write ignored.
